bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Purpose : sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Latency : 8 cycles from the Start acceptance edge to the Done pulse.
// Backpressure: none; Start is ignored while Busy, so the requester must hold or retry.
//
// Ports:
//   Clock          rising-edge clock
//   Resetn         asynchronous active-low reset
//   Start          conversion request, sampled only while idle
//   Bin[7:0]       unsigned operand, captured on acceptance
//   Busy           high while a conversion is running
//   Done           one-cycle pulse when BCD2/BCD1/BCD0 take a new result
//   BCD2/BCD1/BCD0 hundreds/tens/units digits, held until the next Done
//   Blank2/Blank1  leading-zero blank flags (only with BIN2BCD_LZB_EN defined)
//
// Optional feature macro: BIN2BCD_LZB_EN adds the leading-zero blank flags.

module bin2bcd_seq (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [7:0] Bin,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0
`ifdef BIN2BCD_LZB_EN
  ,
  output logic       Blank2,
  output logic       Blank1
`endif
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [2:0]  iter;

  logic [11:0] adj;
  logic [11:0] scratch_nxt;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the next
  // operand bit into the bottom of the scratch register.
  always_comb begin
    adj = scratch;
    if (scratch[3:0]  >= 4'd5) adj[3:0]  = scratch[3:0]  + 4'd3;
    if (scratch[7:4]  >= 4'd5) adj[7:4]  = scratch[7:4]  + 4'd3;
    if (scratch[11:8] >= 4'd5) adj[11:8] = scratch[11:8] + 4'd3;
    scratch_nxt = (adj << 1) | {11'd0, shreg[7]};
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      shreg   <= 8'd0;
      scratch <= 12'd0;
      iter    <= 3'd0;
      BCD2    <= 4'd0;
      BCD1    <= 4'd0;
      BCD0    <= 4'd0;
`ifdef BIN2BCD_LZB_EN
      Blank2  <= 1'b1;
      Blank1  <= 1'b1;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= CONV;
            Busy    <= 1'b1;
            shreg   <= Bin;
            scratch <= 12'd0;
            iter    <= 3'd0;
          end
        end
        CONV: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          iter    <= iter + 3'd1;
          // Eighth shift: publish the digits straight from the final step so
          // the result appears on the same edge the FSM returns to idle.
          if (iter == 3'd7) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            BCD2  <= scratch_nxt[11:8];
            BCD1  <= scratch_nxt[7:4];
            BCD0  <= scratch_nxt[3:0];
`ifdef BIN2BCD_LZB_EN
            Blank2 <= (scratch_nxt[11:8] == 4'd0);
            Blank1 <= (scratch_nxt[11:4] == 8'd0);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
